// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side resolution signals for branch_predictor.
// The slave modport is the predictor; the master modport is the pipeline driving it.
interface branch_predictor_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
);
    logic [DW-1:0]    fetch_pc_i;
    logic             pred_taken_o;
    logic [DW-1:0]    pred_target_o;
    logic             ex_valid_i;
    logic             ex_is_branch_i;
    logic [DW-1:0]    ex_pc_i;
    logic [DW-1:0]    ex_target_i;
    logic             ex_pred_taken_i;
    logic [DW-1:0]    ex_pred_target_i;
    logic             branch_i;
    logic             mispredict_o;
    logic [DW-1:0]    redirect_pc_o;
    logic [CNT_W-1:0] branch_count_o;
    logic [CNT_W-1:0] mispredict_count_o;

    modport slave (
        input  fetch_pc_i, ex_valid_i, ex_is_branch_i, ex_pc_i, ex_target_i,
               ex_pred_taken_i, ex_pred_target_i, branch_i,
        output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               branch_count_o, mispredict_count_o
    );

    modport master (
        output fetch_pc_i, ex_valid_i, ex_is_branch_i, ex_pc_i, ex_target_i,
               ex_pred_taken_i, ex_pred_target_i, branch_i,
        input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               branch_count_o, mispredict_count_o
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit-counter BHT with tagged BTB: zero-latency fetch prediction, execute-stage
// training, registered one-cycle mispredict redirect and saturating statistics.
module branch_predictor #(
    parameter int unsigned DW    = 32,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = DW - IDX_W - 2;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [DW-1:0]    r_target [ENTRIES];
    logic [1:0]       r_cnt    [ENTRIES];

    logic             r_mispredict;
    logic [DW-1:0]    r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_f_taken;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic [1:0]       w_ex_cnt;
    logic             w_resolve;
    logic             w_mis_cond;
    logic [DW-1:0]    w_redirect;
    logic             w_unused;

    // Fetch lookup reads the table as of the last edge, never the pending update.
    assign w_f_idx   = bp.fetch_pc_i[IDX_W+1:2];
    assign w_f_tag   = bp.fetch_pc_i[DW-1:IDX_W+2];
    assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken = w_f_hit && r_cnt[w_f_idx][1];

    assign bp.pred_taken_o  = w_f_taken;
    assign bp.pred_target_o = w_f_taken ? r_target[w_f_idx] : bp.fetch_pc_i + DW'(4);

    // Execute side; a live mispredict pulse marks the current ex inputs as wrong-path.
    assign w_ex_idx   = bp.ex_pc_i[IDX_W+1:2];
    assign w_ex_tag   = bp.ex_pc_i[DW-1:IDX_W+2];
    assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_ex_cnt   = r_cnt[w_ex_idx];
    assign w_resolve  = bp.ex_valid_i && bp.ex_is_branch_i && !r_mispredict;
    assign w_mis_cond = (bp.ex_pred_taken_i != bp.branch_i) ||
                        (bp.branch_i && (bp.ex_pred_target_i != bp.ex_target_i));
    assign w_redirect = bp.branch_i ? bp.ex_target_i : bp.ex_pc_i + DW'(4);

    assign w_unused = ^{bp.fetch_pc_i[1:0], bp.ex_pc_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid          <= '{default: 1'b0};
            r_tag            <= '{default: '0};
            r_target         <= '{default: '0};
            r_cnt            <= '{default: 2'b01};
            r_mispredict     <= 1'b0;
            r_redirect_pc    <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_mispredict <= w_resolve && w_mis_cond;
            if (w_resolve && w_mis_cond) begin
                r_redirect_pc <= w_redirect;
            end
            if (w_resolve) begin
                if (w_ex_hit) begin
                    if (bp.branch_i) begin
                        r_cnt[w_ex_idx]    <= (w_ex_cnt == 2'b11) ? w_ex_cnt : w_ex_cnt + 2'd1;
                        r_target[w_ex_idx] <= bp.ex_target_i;
                    end else begin
                        r_cnt[w_ex_idx]    <= (w_ex_cnt == 2'b00) ? w_ex_cnt : w_ex_cnt - 2'd1;
                    end
                end else if (bp.branch_i) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= bp.ex_target_i;
                    r_cnt[w_ex_idx]    <= 2'b10;
                end
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                end
                if (w_mis_cond && (r_mispredict_cnt != '1)) begin
                    r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bp.mispredict_o       = r_mispredict;
    assign bp.redirect_pc_o      = r_redirect_pc;
    assign bp.branch_count_o     = r_branch_cnt;
    assign bp.mispredict_count_o = r_mispredict_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_branch_predictor;
    localparam int unsigned DW    = 32;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned N     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.DW(DW), .CNT_W(CNT_W)) bif ();

    branch_predictor #(.DW(DW), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per table slot, strength held as a plain 0..3 integer.
    bit          m_ready = 1'b0;
    bit          m_valid [N];
    logic [31:0] m_tagpc [N];
    logic [31:0] m_tgt   [N];
    int          m_str   [N];
    bit          m_mis;
    logic [31:0] m_redir;
    int          m_bc, m_mc;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit model_taken(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && (m_tagpc[s] == (pc >> 6)) && (m_str[s] >= 2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0; m_tagpc[i] = '0; m_tgt[i] = '0; m_str[i] = 1;
            end
            m_mis = 1'b0; m_redir = '0; m_bc = 0; m_mc = 0; m_ready = 1'b1;
        end else begin
            bit   ev, wrong, hit;
            int   s;
            ev    = bif.ex_valid_i && bif.ex_is_branch_i && !m_mis;
            wrong = (bif.ex_pred_taken_i != bif.branch_i) ||
                    (bif.branch_i && (bif.ex_pred_target_i != bif.ex_target_i));
            s     = slot(bif.ex_pc_i);
            hit   = m_valid[s] && (m_tagpc[s] == (bif.ex_pc_i >> 6));
            if (ev) begin
                if (hit && bif.branch_i) begin
                    m_str[s] = (m_str[s] + 1 > 3) ? 3 : m_str[s] + 1;
                    m_tgt[s] = bif.ex_target_i;
                end else if (hit) begin
                    m_str[s] = (m_str[s] - 1 < 0) ? 0 : m_str[s] - 1;
                end else if (bif.branch_i) begin
                    m_valid[s] = 1'b1; m_tagpc[s] = bif.ex_pc_i >> 6;
                    m_tgt[s] = bif.ex_target_i; m_str[s] = 2;
                end
                m_bc = (m_bc >= 65535) ? 65535 : m_bc + 1;
                if (wrong) m_mc = (m_mc >= 65535) ? 65535 : m_mc + 1;
                if (wrong) m_redir = bif.branch_i ? bif.ex_target_i : bif.ex_pc_i + 32'd4;
            end
            m_mis = ev && wrong;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ready && !rst) begin
            bit t;
            t = model_taken(bif.fetch_pc_i);
            chk("pred_taken", 32'(bif.pred_taken_o), 32'(t));
            chk("pred_target", bif.pred_target_o,
                t ? m_tgt[slot(bif.fetch_pc_i)] : bif.fetch_pc_i + 32'd4);
            chk("mispredict", 32'(bif.mispredict_o), 32'(m_mis));
            if (m_mis) chk("redirect_pc", bif.redirect_pc_o, m_redir);
            chk("branch_count", 32'(bif.branch_count_o), 32'(m_bc));
            chk("mispredict_count", 32'(bif.mispredict_count_o), 32'(m_mc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                          input logic [31:0] ptgt, input logic br);
        bif.ex_valid_i = 1'b1; bif.ex_is_branch_i = 1'b1;
        bif.ex_pc_i = pc; bif.ex_target_i = tgt;
        bif.ex_pred_taken_i = pt; bif.ex_pred_target_i = ptgt; bif.branch_i = br;
    endtask

    // One resolve event, then an idle cycle so the next event is never a shadow.
    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                           input logic [31:0] ptgt, input logic br);
        set_ex(pc, tgt, pt, ptgt, br);
        tick();
        bif.ex_valid_i = 1'b0;
        tick();
    endtask

    task automatic chk_fetch(input string name, input logic [31:0] pc,
                             input logic taken, input logic [31:0] tgt);
        bif.fetch_pc_i = pc;
        #1;
        chk({name, "_taken"}, 32'(bif.pred_taken_o), 32'(taken));
        chk({name, "_target"}, bif.pred_target_o, tgt);
    endtask

    initial begin
        bif.fetch_pc_i = 32'h100; bif.ex_valid_i = 1'b0; bif.ex_is_branch_i = 1'b0;
        bif.ex_pc_i = '0; bif.ex_target_i = '0; bif.ex_pred_taken_i = 1'b0;
        bif.ex_pred_target_i = '0; bif.branch_i = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk_fetch("reset_fetch", 32'h100, 1'b0, 32'h104);
        chk("reset_mispredict", 32'(bif.mispredict_o), 32'h0);
        chk("reset_bc", 32'(bif.branch_count_o), 32'h0);
        chk("reset_mc", 32'(bif.mispredict_count_o), 32'h0);

        // Allocation with a not-taken prediction mispredicts to the target.
        set_ex(32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
        tick();
        bif.ex_valid_i = 1'b0;
        chk("alloc_mispredict", 32'(bif.mispredict_o), 32'h1);
        chk("alloc_redirect", bif.redirect_pc_o, 32'h80);
        chk("alloc_bc", 32'(bif.branch_count_o), 32'h1);
        chk("alloc_mc", 32'(bif.mispredict_count_o), 32'h1);
        tick();
        chk("pulse_end", 32'(bif.mispredict_o), 32'h0);
        chk_fetch("alloc_fetch", 32'h100, 1'b1, 32'h80);

        // Counter walk: 10 -> 01 -> 00, then four taken saturate at 11.
        resolve(32'h100, 32'h80, 1'b1, 32'h80, 1'b0);
        chk_fetch("walk_01", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 32'h80, 1'b0, 32'h104, 1'b0);
        chk_fetch("walk_00", 32'h100, 1'b0, 32'h104);
        for (int i = 0; i < 4; i++) resolve(32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
        chk_fetch("walk_sat", 32'h100, 1'b1, 32'h80);
        resolve(32'h100, 32'h80, 1'b1, 32'h80, 1'b0);
        chk_fetch("walk_sat_dec1", 32'h100, 1'b1, 32'h80);
        resolve(32'h100, 32'h80, 1'b1, 32'h80, 1'b0);
        chk_fetch("walk_sat_dec2", 32'h100, 1'b0, 32'h104);

        // Aliasing: 0x140 shares the slot of 0x100 with a different tag.
        resolve(32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
        chk_fetch("alias_other", 32'h140, 1'b0, 32'h144);
        resolve(32'h140, 32'h200, 1'b0, 32'h144, 1'b1);
        chk_fetch("alias_evicted", 32'h100, 1'b0, 32'h104);
        chk_fetch("alias_new", 32'h140, 1'b1, 32'h200);

        // Shadow cycle ignored; same-cycle fetch sees the pre-update entry.
        set_ex(32'h204, 32'h300, 1'b0, 32'h208, 1'b1);
        chk_fetch("same_cycle_old", 32'h204, 1'b0, 32'h208);
        tick();
        set_ex(32'h208, 32'h400, 1'b0, 32'h20c, 1'b1);
        chk("shadow_pulse", 32'(bif.mispredict_o), 32'h1);
        chk("shadow_redirect", bif.redirect_pc_o, 32'h300);
        tick();
        bif.ex_valid_i = 1'b0;
        chk("shadow_no_count", 32'(bif.branch_count_o), 32'd12);
        chk("shadow_mispredict_clear", 32'(bif.mispredict_o), 32'h0);
        chk_fetch("shadow_no_train", 32'h208, 1'b0, 32'h20c);
        chk_fetch("shadow_updated", 32'h204, 1'b1, 32'h300);
        tick();

        // Target mismatch with correct direction, then reset kills the pulse.
        set_ex(32'h20, 32'h44, 1'b1, 32'h40, 1'b1);
        tick();
        bif.ex_valid_i = 1'b0;
        chk("tgt_mispredict", 32'(bif.mispredict_o), 32'h1);
        chk("tgt_redirect", bif.redirect_pc_o, 32'h44);
        rst = 1'b1;
        tick();
        chk("rst_kills_pulse", 32'(bif.mispredict_o), 32'h0);
        chk("rst_clears_bc", 32'(bif.branch_count_o), 32'h0);
        rst = 1'b0;
        chk_fetch("rst_clears_table", 32'h20, 1'b0, 32'h24);

        // Statistics saturation with back-to-back correctly predicted not-taken branches.
        set_ex(32'h1000, 32'h2000, 1'b0, 32'h1004, 1'b0);
        for (int i = 0; i < 65540; i++) tick();
        bif.ex_valid_i = 1'b0;
        chk("bc_saturated", 32'(bif.branch_count_o), 32'hFFFF);
        chk("mc_after_sat", 32'(bif.mispredict_count_o), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
